restoring_div8: RTL and testbench

//  Iterative unsigned restoring divider; the subtract-side counterpart of the 8-bit CLA adder.

---
 rtl/arith_pkg.sv | 12 +
 rtl/sub_borrow.sv | 33 +++
 rtl/restoring_div8.sv | 101 ++++++++++
 tb/tb_restoring_div8.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM encoding and default operand width.
package arith_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/sub_borrow.sv
// Combinational (WIDTH+1)-bit subtractor a - b, formed as a + ~b + 1 on the CLA
// generate/propagate carry structure; borrow is the sign bit of the difference.
module sub_borrow #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] nb;
    logic [WIDTH:0] g;
    logic [WIDTH:0] p;
    logic [WIDTH:0] c;
    logic [WIDTH:0] sum;

    always_comb begin
        nb   = ~b;
        g    = a & nb;
        p    = a ^ nb;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum    = p ^ c;
        diff   = sum[WIDTH-1:0];
        // a < 2*b always holds in the divider, so the top bit is a clean borrow flag
        borrow = sum[WIDTH];
    end

endmodule

// File: rtl/restoring_div8.sv
// Iterative unsigned restoring divider: one shift-subtract step per clock,
// quotient/remainder returned with a one-cycle done pulse.
module restoring_div8
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic             dz;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;

    sub_borrow #(.WIDTH(WIDTH)) u_sub (
        .a      ({rem, q[WIDTH-1]}),
        .b      ({1'b0, dvsr}),
        .diff   (trial),
        .borrow (borrow)
    );

    assign rem_next = borrow ? {rem[WIDTH-2:0], q[WIDTH-1]} : trial;
    assign q_next   = {q[WIDTH-2:0], ~borrow};
    // The done cycle is still part of the finishing handshake, so a start there is dropped.
    assign accept   = (state == IDLE) && start && !done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            count       <= '0;
            dz          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        count       <= '0;
                        dvsr        <= divisor;
                        if (divisor == '0) begin
                            q     <= '1;
                            rem   <= dividend;
                            dz    <= 1'b1;
                            state <= FIN;
                        end else begin
                            q     <= dividend;
                            rem   <= '0;
                            dz    <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    quotient    <= q;
                    remainder   <= rem;
                    div_by_zero <= dz;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_div8.sv
// Directed and swept checks of restoring_div8 against hand-computed and / % reference values.
module tb_restoring_div8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int passed = 0;
    int total  = 0;

    restoring_div8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Pulse start for one cycle, then wait for done while scrambling the operand ports.
    // kind 1 additionally pulses a competing start (50/5) two cycles into the operation.
    task automatic run_op(input logic [7:0] dd, input logic [7:0] dv, input int kind,
                          output int lat, output int busyc);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        busyc = 0;
        while (!done && lat < 30) begin
            if (busy) busyc++;
            if (kind == 1 && lat == 2) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end else begin
                start    = 1'b0;
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic ref_op(input logic [7:0] dd, input logic [7:0] dv);
        int lat;
        int busyc;
        logic [7:0] eq;
        logic [7:0] er;
        eq = (dv == 0) ? 8'hFF : dd / dv;
        er = (dv == 0) ? dd : dd % dv;
        run_op(dd, dv, 0, lat, busyc);
        chk($sformatf("sweep_q %0d/%0d", dd, dv), quotient, eq);
        chk($sformatf("sweep_r %0d/%0d", dd, dv), remainder, er);
        chk($sformatf("sweep_dz %0d/%0d", dd, dv), div_by_zero, (dv == 0));
        chk($sformatf("sweep_lat %0d/%0d", dd, dv), lat, (dv == 0) ? 1 : 9);
    endtask

    initial begin
        int lat;
        int busyc;
        int extra;
        logic [7:0] dvs [13];

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        rst_n = 1'b1;

        // 200/7 = 28 r 4, busy for nine cycles
        run_op(8'd200, 8'd7, 0, lat, busyc);
        chk("t1_lat", lat, 9);
        chk("t1_busy_cycles", busyc, 9);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_q", quotient, 28);
        chk("t1_r", remainder, 4);
        chk("t1_dz", div_by_zero, 0);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_q_hold", quotient, 28);

        run_op(8'd255, 8'd1, 0, lat, busyc);
        chk("t2a_q", quotient, 255);
        chk("t2a_r", remainder, 0);
        run_op(8'd5, 8'd9, 0, lat, busyc);
        chk("t2b_q", quotient, 0);
        chk("t2b_r", remainder, 5);
        run_op(8'd0, 8'd3, 0, lat, busyc);
        chk("t2c_q", quotient, 0);
        chk("t2c_r", remainder, 0);
        run_op(8'd255, 8'd255, 0, lat, busyc);
        chk("t2d_q", quotient, 1);
        chk("t2d_r", remainder, 0);

        // 77/0 finishes one cycle after acceptance
        run_op(8'd77, 8'd0, 0, lat, busyc);
        chk("t3_lat", lat, 1);
        chk("t3_q", quotient, 8'hFF);
        chk("t3_r", remainder, 77);
        chk("t3_dz", div_by_zero, 1);
        run_op(8'd10, 8'd3, 0, lat, busyc);
        chk("t3b_dz", div_by_zero, 0);
        chk("t3b_q", quotient, 3);
        chk("t3b_r", remainder, 1);
        // start coinciding with done is dropped
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        @(negedge clk);
        start = 1'b0;
        chk("t3c_start_on_done_busy", busy, 0);
        @(negedge clk);
        chk("t3c_start_on_done_nodone", done, 0);
        chk("t3c_q_hold", quotient, 3);

        // competing start mid-operation is ignored
        run_op(8'd100, 8'd9, 1, lat, busyc);
        chk("t4_lat", lat, 9);
        chk("t4_q", quotient, 11);
        chk("t4_r", remainder, 1);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("t4_single_done", extra, 0);

        // reset mid-operation abandons the op
        dividend = 8'd180;
        divisor  = 8'd11;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_q", quotient, 0);
        chk("t5_r", remainder, 0);
        chk("t5_dz", div_by_zero, 0);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("t5_no_done", extra, 0);
        run_op(8'd180, 8'd11, 0, lat, busyc);
        chk("t5b_q", quotient, 16);
        chk("t5b_r", remainder, 4);

        // swept grid of operands, including divisor 0, then random pairs
        dvs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd8, 8'd15, 8'd16,
                8'd127, 8'd128, 8'd200, 8'd254, 8'd255};
        foreach (dvs[j]) begin
            for (int i = 0; i < 256; i += 17) begin
                ref_op(8'(i), dvs[j]);
            end
        end
        for (int k = 0; k < 200; k++) begin
            ref_op(8'($urandom), 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
